// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Boot loader. Assembles a framed little-endian byte stream into
//             32-bit words, writes them to memory and verifies an XOR checksum.
//  Revision : 1.0  initial release
// ============================================================================
module prog_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rxData,
  input  logic                  rxValid,
  output logic                  rxReady,
  output logic                  memWrEn,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [31:0]           memWData,
  input  logic                  memReady,
  input  logic                  restart,
  output logic                  coreRun,
  output logic                  busy,
  output logic                  err
);

  localparam int          CNT_W       = $clog2(MAX_WORDS + 1);
  localparam logic [31:0] C_MAX_WORDS = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_DATA  = 3'd1,
    S_WRITE = 3'd2,
    S_CHK   = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t           r_state;
  logic [1:0]       r_byteCnt;
  logic [CNT_W-1:0] r_wordCnt;
  logic [31:0]      r_numWords;
  logic [23:0]      r_word;      // lanes 0..2; lane 3 goes straight to memWData
  logic [7:0]       r_checksum;

  logic        w_rxFire;
  logic [31:0] w_hdrNext;
  logic        w_lastWord;

  assign w_rxFire   = rxValid && rxReady;
  assign w_hdrNext  = {rxData, r_numWords[31:8]};
  assign w_lastWord = (32'(r_wordCnt) + 32'd1) == r_numWords;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_HDR;
      r_byteCnt  <= '0;
      r_wordCnt  <= '0;
      r_numWords <= '0;
      r_word     <= '0;
      r_checksum <= '0;
      rxReady    <= 1'b0;
      memWrEn    <= 1'b0;
      memAddr    <= BASE_ADDR;
      memWData   <= '0;
      coreRun    <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (r_state)
        S_HDR: begin
          rxReady <= 1'b1;
          busy    <= 1'b1;
          if (w_rxFire) begin
            r_numWords <= w_hdrNext;
            r_byteCnt  <= r_byteCnt + 2'd1;
            if (r_byteCnt == 2'd3) begin
              if (w_hdrNext > C_MAX_WORDS) begin
                r_state <= S_ERROR;
                err     <= 1'b1;
                busy    <= 1'b0;
                rxReady <= 1'b0;
              end else if (w_hdrNext == '0) begin
                r_state <= S_CHK;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (w_rxFire) begin
            r_checksum <= r_checksum ^ rxData;
            r_byteCnt  <= r_byteCnt + 2'd1;
            case (r_byteCnt)
              2'd0: r_word[7:0]   <= rxData;
              2'd1: r_word[15:8]  <= rxData;
              2'd2: r_word[23:16] <= rxData;
              default: begin
                memWData <= {rxData, r_word};
                memWrEn  <= 1'b1;
                rxReady  <= 1'b0;
                r_state  <= S_WRITE;
              end
            endcase
          end
        end

        S_WRITE: begin
          // Address and data are held until the memory takes the write
          if (memWrEn && memReady) begin
            memWrEn   <= 1'b0;
            memAddr   <= memAddr + ADDR_WIDTH'(4);
            r_wordCnt <= r_wordCnt + CNT_W'(1);
            rxReady   <= 1'b1;
            r_state   <= w_lastWord ? S_CHK : S_DATA;
          end
        end

        S_CHK: begin
          if (w_rxFire) begin
            rxReady <= 1'b0;
            busy    <= 1'b0;
            if (rxData == r_checksum) begin
              r_state <= S_DONE;
              coreRun <= 1'b1;
            end else begin
              r_state <= S_ERROR;
              err     <= 1'b1;
            end
          end
        end

        S_DONE, S_ERROR: begin
          if (restart) begin
            r_state    <= S_HDR;
            r_byteCnt  <= '0;
            r_wordCnt  <= '0;
            r_numWords <= '0;
            r_checksum <= '0;
            memAddr    <= BASE_ADDR;
            coreRun    <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b1;
            rxReady    <= 1'b1;
          end
        end

        default: begin
          r_state <= S_HDR;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Randomized self-checking bench for prog_loader against a
//             frame-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_loader;

  localparam int          MAXW = 1024;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rxData = 8'h00;
  logic        rxValid = 1'b0;
  logic        rxReady;
  logic        memWrEn;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic        memReady = 1'b0;
  logic        restart = 1'b0;
  logic        coreRun;
  logic        busy;
  logic        err;

  prog_loader #(
    .ADDR_WIDTH(32),
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAXW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rxData  (rxData),
    .rxValid (rxValid),
    .rxReady (rxReady),
    .memWrEn (memWrEn),
    .memAddr (memAddr),
    .memWData(memWData),
    .memReady(memReady),
    .restart (restart),
    .coreRun (coreRun),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  int          vecCnt = 0;
  int          errCnt = 0;
  byte unsigned frame[$];
  logic [31:0] expAddrQ[$];
  logic [31:0] expDataQ[$];
  logic [31:0] gotAddr[$];
  logic [31:0] gotData[$];
  bit          expOk;
  logic [7:0]  lastSum;
  bit          checkOn = 1'b0;
  int          stallLeft = 0;
  int          readyPct = 100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: builds the byte stream and the writes it must produce
  task automatic buildFrame(input logic [31:0] n, input logic [31:0] words[$], input bit badSum);
    logic [7:0] sum;
    sum = 8'h00;
    frame.delete();
    expAddrQ.delete();
    expDataQ.delete();
    gotAddr.delete();
    gotData.delete();
    for (int i = 0; i < 4; i++) frame.push_back(n[8*i +: 8]);
    if (n > MAXW) begin
      expOk = 1'b0;
      return;
    end
    for (int w = 0; w < int'(n); w++) begin
      for (int b = 0; b < 4; b++) begin
        frame.push_back(words[w][8*b +: 8]);
        sum = sum ^ words[w][8*b +: 8];
      end
      expAddrQ.push_back(BASE + 32'(4 * w));
      expDataQ.push_back(words[w]);
    end
    lastSum = sum;
    frame.push_back(badSum ? (sum ^ 8'(($urandom_range(254) + 1))) : sum);
    expOk = !badSum;
  endtask

  task automatic sendBytes(input int count, input int idlePct);
    int idx;
    int budget;
    idx = 0;
    budget = 20000;
    while (idx < count && budget > 0) begin
      @(negedge clk);
      budget--;
      if ($urandom_range(99) < idlePct) begin
        rxValid = 1'b0;
        rxData  = 8'($urandom);
      end else begin
        rxValid = 1'b1;
        rxData  = frame[idx];
        if (rxReady) idx++;
      end
    end
    check("send_complete", idx, count);
    @(posedge clk);
    #1;
    rxValid = 1'b0;
  endtask

  task automatic waitOutcome(input bit ok);
    int cyc;
    cyc = 0;
    while (!(coreRun || err) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("outcome_in_time", cyc < 2000, 1);
    check("coreRun", coreRun, ok);
    check("err", err, !ok);
    check("busy_idle", busy, 0);
    check("rxReady_idle", rxReady, 0);
    check("writes_pending", expAddrQ.size(), 0);
  endtask

  task automatic doRestart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rs_busy", busy, 1);
    check("rs_rxReady", rxReady, 1);
    check("rs_coreRun", coreRun, 0);
    check("rs_err", err, 0);
    check("rs_memAddr", memAddr, BASE);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_rxReady"}, rxReady, 0);
    check({tag, "_memWrEn"}, memWrEn, 0);
    check({tag, "_memAddr"}, memAddr, BASE);
    check({tag, "_memWData"}, memWData, 0);
    check({tag, "_coreRun"}, coreRun, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Memory side: random acceptance, optionally a forced stall on a write
  always @(negedge clk) begin
    if (memWrEn && stallLeft > 0) begin
      memReady = 1'b0;
      stallLeft--;
    end else begin
      memReady = ($urandom_range(99) < readyPct);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (checkOn && reset) begin
      check("rxReady_vs_busy", rxReady, busy && !memWrEn);
      check("busy_vs_status", busy, !(coreRun || err));
      check("run_err_exclusive", coreRun && err, 0);
      if (memWrEn) begin
        check("write_expected", expAddrQ.size() != 0, 1);
        if (expAddrQ.size() != 0) begin
          check("wr_addr", memAddr, expAddrQ[0]);
          check("wr_data", memWData, expDataQ[0]);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (reset && memWrEn && memReady) begin
      gotAddr.push_back(memAddr);
      gotData.push_back(memWData);
      if (expAddrQ.size() != 0) begin
        void'(expAddrQ.pop_front());
        void'(expDataQ.pop_front());
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[$];

    repeat (3) @(negedge clk);
    checkResetValues("rst");
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 1);
    check("post_rst_rxReady", rxReady, 1);
    checkOn = 1'b1;

    // Single word, literal expectations pin the model
    w = '{32'h12345678};
    buildFrame(32'd1, w, 1'b0);
    check("model_sum", lastSum, 8'h08);
    sendBytes(frame.size(), 0);
    waitOutcome(expOk);
    check("n1_count", gotAddr.size(), 1);
    check("n1_addr", gotAddr[0], 32'h0);
    check("n1_data", gotData[0], 32'h12345678);

    // Extra bytes in DONE are not consumed
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rxValid = 1'b1;
      rxData  = 8'hA5;
      check("done_rxReady", rxReady, 0);
      check("done_coreRun", coreRun, 1);
    end
    rxValid = 1'b0;

    // Two words with a 5-cycle stall on the first write
    doRestart();
    w = '{$urandom, $urandom};
    buildFrame(32'd2, w, 1'b0);
    stallLeft = 5;
    sendBytes(frame.size(), 0);
    waitOutcome(expOk);
    check("n2_count", gotAddr.size(), 2);
    check("n2_addr0", gotAddr[0], 32'h0);
    check("n2_addr1", gotAddr[1], 32'h4);

    // Empty image, good and bad checksum
    doRestart();
    w.delete();
    buildFrame(32'd0, w, 1'b0);
    sendBytes(frame.size(), 0);
    waitOutcome(1'b1);
    doRestart();
    frame.delete();
    frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    sendBytes(frame.size(), 0);
    waitOutcome(1'b0);
    check("n0_writes", gotAddr.size(), 0);

    // Oversized header
    doRestart();
    buildFrame(32'(MAXW + 1), w, 1'b0);
    sendBytes(frame.size(), 0);
    check("big_err_now", err, 1);
    check("big_rxReady_now", rxReady, 0);
    waitOutcome(expOk);
    check("big_writes", gotAddr.size(), 0);

    // Three words with a bad checksum, then recovery
    doRestart();
    w = '{$urandom, $urandom, $urandom};
    buildFrame(32'd3, w, 1'b1);
    sendBytes(frame.size(), 10);
    waitOutcome(1'b0);
    check("n3_writes", gotAddr.size(), 3);
    doRestart();
    w = '{$urandom};
    buildFrame(32'd1, w, 1'b0);
    sendBytes(frame.size(), 0);
    waitOutcome(1'b1);

    // Randomized frames
    readyPct = 60;
    for (int f = 0; f < 12; f++) begin
      int n;
      doRestart();
      n = $urandom_range(1, 6);
      w.delete();
      for (int k = 0; k < n; k++) w.push_back($urandom);
      buildFrame(32'(n), w, ($urandom_range(3) == 0));
      sendBytes(frame.size(), 30);
      waitOutcome(expOk);
      check("rand_writes", gotAddr.size(), n);
    end

    // Asynchronous reset in the middle of word 1
    doRestart();
    w = '{$urandom, $urandom};
    buildFrame(32'd2, w, 1'b0);
    sendBytes(4 + 6, 0);
    #2;
    checkOn = 1'b0;
    reset = 1'b0;
    #1;
    checkResetValues("async_rst");
    expAddrQ.delete();
    expDataQ.delete();
    gotAddr.delete();
    gotData.delete();
    repeat (3) @(negedge clk);
    check("rst_no_writes", gotAddr.size(), 0);
    reset = 1'b1;
    @(negedge clk);
    checkOn = 1'b1;
    w = '{$urandom, $urandom};
    buildFrame(32'd2, w, 1'b0);
    sendBytes(frame.size(), 20);
    waitOutcome(1'b1);
    check("after_rst_addr0", gotAddr[0], BASE);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
`default_nettype wire
